// File: rtl/channel_if.sv
// Bus-and-tag cable plus the wrapper-side command and byte-stream signals of one channel.
// master is the channel engine; slave is whatever drives the device and wrapper side.
interface channel_if;
  logic [7:0] a_bus_in;
  logic [7:0] a_bus_out;
  logic       a_operational_out;
  logic       a_request_in;
  logic       a_hold_out;
  logic       a_select_out;
  logic       a_select_in;
  logic       a_address_out;
  logic       a_operational_in;
  logic       a_address_in;
  logic       a_command_out;
  logic       a_status_in;
  logic       a_service_in;
  logic       a_service_out;
  logic       a_suppress_out;
  logic       active;
  logic [7:0] addr;
  logic [7:0] command;
  logic       start;
  logic       stop;
  logic [7:0] status_tdata;
  logic       status_tvalid;
  logic [7:0] data_send_tdata;
  logic       data_send_tvalid;
  logic       data_send_tready;
  logic [7:0] data_recv_tdata;
  logic       data_recv_tvalid;
  logic       data_recv_tready;

  // request-in is carried on the cable but the engine never looks at it.
  modport master (
    input  a_bus_in, a_select_in, a_operational_in, a_address_in, a_status_in, a_service_in,
    input  addr, command, start, stop, data_send_tdata, data_send_tvalid, data_recv_tready,
    output a_bus_out, a_operational_out, a_hold_out, a_select_out, a_address_out,
    output a_command_out, a_service_out, a_suppress_out, active, status_tdata, status_tvalid,
    output data_send_tready, data_recv_tdata, data_recv_tvalid
  );

  modport slave (
    output a_bus_in, a_request_in, a_select_in, a_operational_in, a_address_in, a_status_in,
    output a_service_in, addr, command, start, stop, data_send_tdata, data_send_tvalid,
    output data_recv_tready,
    input  a_bus_out, a_operational_out, a_hold_out, a_select_out, a_address_out,
    input  a_command_out, a_service_out, a_suppress_out, active, status_tdata, status_tvalid,
    input  data_send_tready, data_recv_tdata, data_recv_tvalid
  );
endinterface

// File: rtl/channel.sv
// Bus-and-tag channel engine: selects one device, issues a command, moves data bytes
// between the cable and two byte streams, and reports status bytes.
module channel (
  input  logic      clk,
  input  logic      reset,
  channel_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StSel, StCmd, StWaitIstat, StStatIni, StData, StXfer, StSvcWait,
    StStopWait, StWaitEstat, StStatEnd, StDisc
  } state_e;

  localparam int unsigned TSel  = 0;
  localparam int unsigned TOp   = 1;
  localparam int unsigned TAddr = 2;
  localparam int unsigned TStat = 3;
  localparam int unsigned TSvc  = 4;

  state_e     state_q, state_d;
  logic [4:0] tag_s1_q, tag_s2_q, tag_s3_q;
  logic [7:0] bin_s1_q, bin_s2_q;
  logic [7:0] addr_q, addr_d, cmd_q, cmd_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       address_out_q, address_out_d, command_out_q, command_out_d;
  logic       service_out_q, service_out_d, select_out_q, select_out_d;
  logic       active_q, active_d, oper_q;
  logic [7:0] status_tdata_q, status_tdata_d;
  logic       status_tvalid_q, status_tvalid_d;
  logic       send_tready_q, send_tready_d;
  logic [7:0] recv_tdata_q, recv_tdata_d;
  logic       recv_tvalid_q, recv_tvalid_d;
  logic       stop_pending_q, stop_pending_d;
  logic       addr_rise, addr_fall, stat_rise, stat_fall, svc_rise, svc_fall;

  // Edges are taken between the second and a third stage so a tag-in change reaches the
  // responding tag-out three clocks later.
  assign addr_rise = tag_s2_q[TAddr] & ~tag_s3_q[TAddr];
  assign addr_fall = ~tag_s2_q[TAddr] & tag_s3_q[TAddr];
  assign stat_rise = tag_s2_q[TStat] & ~tag_s3_q[TStat];
  assign stat_fall = ~tag_s2_q[TStat] & tag_s3_q[TStat];
  assign svc_rise  = tag_s2_q[TSvc] & ~tag_s3_q[TSvc];
  assign svc_fall  = ~tag_s2_q[TSvc] & tag_s3_q[TSvc];

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_s1_q <= '0;
      tag_s2_q <= '0;
      tag_s3_q <= '0;
      bin_s1_q <= '0;
      bin_s2_q <= '0;
    end else begin
      tag_s1_q <= {bus.a_service_in, bus.a_status_in, bus.a_address_in,
                   bus.a_operational_in, bus.a_select_in};
      tag_s2_q <= tag_s1_q;
      tag_s3_q <= tag_s2_q;
      bin_s1_q <= bus.a_bus_in;
      bin_s2_q <= bin_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      cmd_q           <= '0;
      bus_out_q       <= '0;
      address_out_q   <= 1'b0;
      command_out_q   <= 1'b0;
      service_out_q   <= 1'b0;
      select_out_q    <= 1'b0;
      active_q        <= 1'b0;
      oper_q          <= 1'b0;
      status_tdata_q  <= '0;
      status_tvalid_q <= 1'b0;
      send_tready_q   <= 1'b0;
      recv_tdata_q    <= '0;
      recv_tvalid_q   <= 1'b0;
      stop_pending_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      cmd_q           <= cmd_d;
      bus_out_q       <= bus_out_d;
      address_out_q   <= address_out_d;
      command_out_q   <= command_out_d;
      service_out_q   <= service_out_d;
      select_out_q    <= select_out_d;
      active_q        <= active_d;
      oper_q          <= 1'b1;
      status_tdata_q  <= status_tdata_d;
      status_tvalid_q <= status_tvalid_d;
      send_tready_q   <= send_tready_d;
      recv_tdata_q    <= recv_tdata_d;
      recv_tvalid_q   <= recv_tvalid_d;
      stop_pending_q  <= stop_pending_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cmd_d           = cmd_q;
    bus_out_d       = bus_out_q;
    address_out_d   = address_out_q;
    command_out_d   = command_out_q;
    service_out_d   = service_out_q;
    select_out_d    = select_out_q;
    active_d        = active_q;
    status_tdata_d  = status_tdata_q;
    status_tvalid_d = 1'b0;
    send_tready_d   = send_tready_q;
    recv_tdata_d    = recv_tdata_q;
    recv_tvalid_d   = recv_tvalid_q;
    stop_pending_d  = stop_pending_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d        = bus.addr;
          cmd_d         = bus.command;
          bus_out_d     = bus.addr;
          address_out_d = 1'b1;
          active_d      = 1'b1;
          state_d       = StSel;
        end
      end
      StSel: begin
        select_out_d = 1'b1;
        // Select-in coming back before operational-in means nobody answered.
        if (tag_s2_q[TSel] && !tag_s2_q[TOp]) begin
          select_out_d  = 1'b0;
          address_out_d = 1'b0;
          bus_out_d     = '0;
          active_d      = 1'b0;
          state_d       = StIdle;
        end else if (tag_s2_q[TOp] && addr_rise) begin
          address_out_d = 1'b0;
          if (bin_s2_q == addr_q) begin
            bus_out_d     = cmd_q;
            command_out_d = 1'b1;
            state_d       = StCmd;
          end else begin
            bus_out_d = '0;
            state_d   = StDisc;
          end
        end
      end
      StCmd: begin
        if (addr_fall) begin
          command_out_d = 1'b0;
          bus_out_d     = '0;
          state_d       = StWaitIstat;
        end
      end
      StWaitIstat, StWaitEstat: begin
        if (stat_rise) begin
          status_tdata_d  = bin_s2_q;
          status_tvalid_d = 1'b1;
          service_out_d   = 1'b1;
          state_d         = (state_q == StWaitIstat) ? StStatIni : StStatEnd;
        end
      end
      StStatIni: begin
        if (stat_fall) begin
          service_out_d = 1'b0;
          state_d       = (status_tdata_q == 8'h00) ? StData : StDisc;
        end
      end
      StStatEnd: begin
        if (stat_fall) begin
          service_out_d = 1'b0;
          state_d       = StDisc;
        end
      end
      StData: begin
        if (stat_rise) begin
          status_tdata_d  = bin_s2_q;
          status_tvalid_d = 1'b1;
          service_out_d   = 1'b1;
          state_d         = StStatEnd;
        end else if (svc_rise) begin
          if (stop_pending_q || bus.stop) begin
            command_out_d  = 1'b1;
            stop_pending_d = 1'b0;
            state_d        = StStopWait;
          end else if (cmd_q[0]) begin
            send_tready_d = 1'b1;
            state_d       = StXfer;
          end else begin
            recv_tdata_d  = bin_s2_q;
            recv_tvalid_d = 1'b1;
            state_d       = StXfer;
          end
        end else if (bus.stop) begin
          stop_pending_d = 1'b1;
        end
      end
      StXfer: begin
        // A handshake landing together with stop still completes; the stop is kept for later.
        if (send_tready_q && bus.data_send_tvalid) begin
          bus_out_d      = bus.data_send_tdata;
          send_tready_d  = 1'b0;
          service_out_d  = 1'b1;
          stop_pending_d = stop_pending_q | bus.stop;
          state_d        = StSvcWait;
        end else if (recv_tvalid_q && bus.data_recv_tready) begin
          recv_tvalid_d  = 1'b0;
          service_out_d  = 1'b1;
          stop_pending_d = stop_pending_q | bus.stop;
          state_d        = StSvcWait;
        end else if (bus.stop) begin
          send_tready_d = 1'b0;
          recv_tvalid_d = 1'b0;
          command_out_d = 1'b1;
          state_d       = StStopWait;
        end
      end
      StSvcWait: begin
        if (bus.stop) stop_pending_d = 1'b1;
        if (svc_fall) begin
          service_out_d = 1'b0;
          bus_out_d     = '0;
          state_d       = StData;
        end
      end
      StStopWait: begin
        if (svc_fall) begin
          command_out_d = 1'b0;
          state_d       = StWaitEstat;
        end
      end
      StDisc: begin
        if (!tag_s2_q[TOp]) begin
          select_out_d   = 1'b0;
          address_out_d  = 1'b0;
          command_out_d  = 1'b0;
          service_out_d  = 1'b0;
          bus_out_d      = '0;
          active_d       = 1'b0;
          stop_pending_d = 1'b0;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.a_bus_out         = bus_out_q;
  assign bus.a_operational_out = oper_q;
  assign bus.a_hold_out        = select_out_q;
  assign bus.a_select_out      = select_out_q;
  assign bus.a_address_out     = address_out_q;
  assign bus.a_command_out     = command_out_q;
  assign bus.a_service_out     = service_out_q;
  assign bus.a_suppress_out    = 1'b0;
  assign bus.active            = active_q;
  assign bus.status_tdata      = status_tdata_q;
  assign bus.status_tvalid     = status_tvalid_q;
  assign bus.data_send_tready  = send_tready_q;
  assign bus.data_recv_tdata   = recv_tdata_q;
  assign bus.data_recv_tvalid  = recv_tvalid_q;

endmodule

// File: tb/tb_channel.sv
// Bench for channel: the initial block plays device and wrapper and queues expected bytes;
// a negedge monitor pops and compares whatever the engine presents.
module tb_channel;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  channel_if ch_if ();
  channel dut (.clk(clk), .reset(reset), .bus(ch_if));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_status[$];
  logic [7:0] exp_recv[$];
  logic [7:0] exp_wr[$];
  logic [7:0] dbytes[0:7];
  logic       cur_write = 1'b0;
  logic       svc_prev = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic out_sel(input int w);
    case (w)
      0: return ch_if.a_address_out;
      1: return ch_if.a_command_out;
      2: return ch_if.a_service_out;
      3: return ch_if.a_select_out;
      4: return ch_if.data_send_tready;
      5: return ch_if.data_recv_tvalid;
      default: return ch_if.active;
    endcase
  endfunction

  task automatic wait_for(input int w, input logic lvl, input string name);
    for (int k = 0; k < 300; k++) begin
      if (out_sel(w) === lvl) return;
      tick();
    end
    n_tests++;
    n_fail++;
    $display("FAIL timeout %s: still %0b, expected %0b", name, out_sel(w), lvl);
  endtask

  always @(negedge clk) begin
    if (ch_if.status_tvalid) begin
      check("status_with_svc_rise", {6'd0, svc_prev, ch_if.a_service_out}, 8'h01);
      if (exp_status.size() == 0) check("status_unexpected", ch_if.status_tdata, 8'hxx);
      else check("status_byte", ch_if.status_tdata, exp_status.pop_front());
    end
    if (ch_if.data_recv_tvalid && ch_if.data_recv_tready) begin
      if (exp_recv.size() == 0) check("recv_unexpected", ch_if.data_recv_tdata, 8'hxx);
      else check("recv_byte", ch_if.data_recv_tdata, exp_recv.pop_front());
    end
    if (cur_write && ch_if.a_service_out && !svc_prev && !ch_if.status_tvalid) begin
      if (exp_wr.size() == 0) check("write_unexpected", ch_if.a_bus_out, 8'hxx);
      else check("write_bus_out", ch_if.a_bus_out, exp_wr.pop_front());
    end
    check("tags_exclusive", {7'd0, ($countones({ch_if.a_address_out, ch_if.a_command_out,
          ch_if.a_service_out}) > 1)}, 8'h00);
    check("hold_eq_select", {7'd0, ch_if.a_hold_out}, {7'd0, ch_if.a_select_out});
    svc_prev <= ch_if.a_service_out;
  end

  task automatic clear_device();
    ch_if.a_bus_in = '0;         ch_if.a_request_in = 1'b0;   ch_if.a_select_in = 1'b0;
    ch_if.a_operational_in = 0;  ch_if.a_address_in = 1'b0;   ch_if.a_status_in = 1'b0;
    ch_if.a_service_in = 1'b0;   ch_if.start = 1'b0;          ch_if.stop = 1'b0;
    ch_if.data_send_tdata = '0;  ch_if.data_send_tvalid = 0;  ch_if.data_recv_tready = 0;
  endtask

  task automatic do_status(input logic [7:0] st);
    ch_if.a_bus_in = st;
    repeat (3) tick();
    exp_status.push_back(st);
    ch_if.a_status_in = 1'b1;
    wait_for(2, 1'b1, "status_svc_up");
    ch_if.a_status_in = 1'b0;
    wait_for(2, 1'b0, "status_svc_down");
  endtask

  task automatic disconnect();
    ch_if.a_operational_in = 1'b0;
    wait_for(3, 1'b0, "disc_select_drop");
    check("active_after_disc", {7'd0, ch_if.active}, 8'h00);
    check("status_all_seen", 8'(exp_status.size()), 8'h00);
    check("recv_all_seen", 8'(exp_recv.size()), 8'h00);
    check("write_all_seen", 8'(exp_wr.size()), 8'h00);
    repeat (3) tick();
  endtask

  // smode: 0 stop while a handshake is pending, 1 stop before the next service-in,
  // 2 the device ends with status on its own.
  task automatic run_op(input logic [7:0] a, input logic [7:0] c, input logic [7:0] echo,
                        input bit nodev, input logic [7:0] istat, input int ndata,
                        input int smode, input logic [7:0] estat, input bit rst_in_data);
    int d;
    cur_write = c[0];
    ch_if.addr = a;
    ch_if.command = c;
    ch_if.start = 1'b1;
    tick();
    ch_if.start = 1'b0;
    check("active_after_start", {7'd0, ch_if.active}, 8'h01);
    check("address_out_after_start", {7'd0, ch_if.a_address_out}, 8'h01);
    check("bus_out_addr", ch_if.a_bus_out, a);
    check("select_not_yet", {7'd0, ch_if.a_select_out}, 8'h00);
    tick();
    check("select_one_later", {7'd0, ch_if.a_select_out}, 8'h01);
    if (nodev) begin
      ch_if.a_select_in = 1'b1;
      wait_for(3, 1'b0, "nodev_select_drop");
      check("nodev_active", {7'd0, ch_if.active}, 8'h00);
      check("nodev_address_out", {7'd0, ch_if.a_address_out}, 8'h00);
      ch_if.a_select_in = 1'b0;
      repeat (4) tick();
      check("nodev_no_status", 8'(exp_status.size()), 8'h00);
      return;
    end
    ch_if.a_operational_in = 1'b1;
    ch_if.a_bus_in = echo;
    repeat (3) tick();
    ch_if.a_address_in = 1'b1;
    if (echo != a) begin
      wait_for(0, 1'b0, "mismatch_address_drop");
      ch_if.a_address_in = 1'b0;
      repeat (5) tick();
      check("mismatch_no_cmd", {7'd0, ch_if.a_command_out}, 8'h00);
      disconnect();
      return;
    end
    wait_for(1, 1'b1, "cmd_out_up");
    check("cmd_bus_out", ch_if.a_bus_out, c);
    ch_if.a_address_in = 1'b0;
    wait_for(1, 1'b0, "cmd_out_down");
    check("bus_out_after_cmd", ch_if.a_bus_out, 8'h00);
    do_status(istat);
    if (istat != 8'h00) begin
      disconnect();
      return;
    end
    if (rst_in_data) begin
      ch_if.a_service_in = 1'b1;
      wait_for(4, 1'b1, "rst_tready");
      reset = 1'b1;
      clear_device();
      tick();
      check("rst_bus_out", ch_if.a_bus_out, 8'h00);
      check("rst_tags", {ch_if.a_operational_out, ch_if.a_select_out, ch_if.a_hold_out,
            ch_if.a_address_out, ch_if.a_command_out, ch_if.a_service_out,
            ch_if.a_suppress_out, ch_if.active}, 8'h00);
      check("rst_streams", {5'd0, ch_if.data_send_tready, ch_if.data_recv_tvalid,
            ch_if.status_tvalid}, 8'h00);
      reset = 1'b0;
      tick();
      check("oper_after_rst", {7'd0, ch_if.a_operational_out}, 8'h01);
      repeat (4) tick();
      return;
    end
    for (int i = 0; i <= ndata; i++) begin
      if (i == ndata) begin
        if (smode == 0) begin
          ch_if.a_bus_in = 8'($urandom);
          repeat (3) tick();
          ch_if.a_service_in = 1'b1;
          wait_for(c[0] ? 4 : 5, 1'b1, "stop_pending_handshake");
          ch_if.stop = 1'b1;
          tick();
          ch_if.stop = 1'b0;
          wait_for(1, 1'b1, "stop_cmd_up");
          check("stop_withdraw", {6'd0, ch_if.data_send_tready, ch_if.data_recv_tvalid}, 8'h00);
          ch_if.a_service_in = 1'b0;
          wait_for(1, 1'b0, "stop_cmd_down");
        end else if (smode == 1) begin
          ch_if.stop = 1'b1;
          tick();
          ch_if.stop = 1'b0;
          ch_if.a_service_in = 1'b1;
          wait_for(1, 1'b1, "pend_cmd_up");
          check("pend_no_svc", {5'd0, ch_if.a_service_out, ch_if.data_send_tready,
                ch_if.data_recv_tvalid}, 8'h00);
          ch_if.a_service_in = 1'b0;
          wait_for(1, 1'b0, "pend_cmd_down");
        end
        do_status(estat);
      end else if (c[0]) begin
        ch_if.a_service_in = 1'b1;
        wait_for(4, 1'b1, "wr_tready");
        d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin
          check("wr_tready_held", {6'd0, ch_if.data_send_tready, ch_if.a_service_out}, 8'h02);
          tick();
        end
        exp_wr.push_back(dbytes[i]);
        ch_if.data_send_tdata = dbytes[i];
        ch_if.data_send_tvalid = 1'b1;
        tick();
        ch_if.data_send_tvalid = 1'b0;
        check("wr_svc_after_hs", {6'd0, ch_if.data_send_tready, ch_if.a_service_out}, 8'h01);
        ch_if.a_service_in = 1'b0;
        wait_for(2, 1'b0, "wr_svc_down");
      end else begin
        ch_if.a_bus_in = dbytes[i];
        repeat (3) tick();
        ch_if.a_service_in = 1'b1;
        wait_for(5, 1'b1, "rd_tvalid");
        exp_recv.push_back(dbytes[i]);
        d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin
          check("rd_svc_before_tready", {7'd0, ch_if.a_service_out}, 8'h00);
          tick();
        end
        ch_if.data_recv_tready = 1'b1;
        tick();
        ch_if.data_recv_tready = 1'b0;
        check("rd_svc_after_hs", {6'd0, ch_if.data_recv_tvalid, ch_if.a_service_out}, 8'h01);
        ch_if.a_service_in = 1'b0;
        wait_for(2, 1'b0, "rd_svc_down");
      end
    end
    disconnect();
  endtask

  initial begin
    logic [7:0] a, c, e;
    reset = 1'b1;
    clear_device();
    ch_if.addr = '0;
    ch_if.command = '0;
    repeat (2) tick();
    check("reset_oper", {7'd0, ch_if.a_operational_out}, 8'h00);
    check("reset_outputs", {ch_if.a_select_out, ch_if.a_address_out, ch_if.a_command_out,
          ch_if.a_service_out, ch_if.active, ch_if.status_tvalid, ch_if.data_send_tready,
          ch_if.data_recv_tvalid}, 8'h00);
    check("reset_bus_out", ch_if.a_bus_out, 8'h00);
    reset = 1'b0;
    tick();
    check("oper_after_reset", {7'd0, ch_if.a_operational_out}, 8'h01);

    dbytes[0] = 8'hA5; dbytes[1] = 8'h5A;
    run_op(8'h40, 8'h01, 8'h40, 1'b0, 8'h00, 2, 0, 8'h0C, 1'b0);
    dbytes[0] = 8'h11; dbytes[1] = 8'h22;
    run_op(8'h40, 8'h02, 8'h40, 1'b0, 8'h00, 2, 2, 8'h0C, 1'b0);
    run_op(8'h40, 8'h01, 8'h40, 1'b1, 8'h00, 0, 0, 8'h00, 1'b0);
    run_op(8'h40, 8'h01, 8'h40, 1'b0, 8'h02, 0, 0, 8'h00, 1'b0);
    run_op(8'h40, 8'h01, 8'h41, 1'b0, 8'h00, 0, 0, 8'h00, 1'b0);
    run_op(8'h40, 8'h01, 8'h40, 1'b0, 8'h00, 0, 0, 8'h00, 1'b1);
    dbytes[0] = 8'h33;
    run_op(8'h27, 8'h03, 8'h27, 1'b0, 8'h00, 1, 1, 8'h04, 1'b0);

    for (int n = 0; n < 20; n++) begin
      a = 8'($urandom);
      c = 8'($urandom);
      e = ($urandom_range(0, 9) == 0) ? (a ^ 8'h01) : a;
      for (int k = 0; k < 8; k++) dbytes[k] = 8'($urandom);
      run_op(a, c, e, ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0) ? 8'h02 : 8'h00,
             $urandom_range(0, 4), $urandom_range(0, 2), 8'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
